// File: rtl/jtag_dr_bank.sv
// Bank of NREG user data registers plus a 1-bit bypass behind a shared TDI->TDO
// shift stage, with per-register shadow copies, update strobes and scan-length checking.
module jtag_dr_bank #(
  parameter int                 NREG      = 4,
  parameter int                 WIDTH     = 32,
  parameter int                 SELW      = 2,
  parameter logic [WIDTH-1:0]   RST_VAL   = '0,
  parameter int                 CHECK_LEN = 1
) (
  input  logic                    tck,
  input  logic                    reset,
  input  logic                    capture_dr,
  input  logic                    shift_dr,
  input  logic                    update_dr,
  input  logic                    bypass,
  input  logic [SELW-1:0]         sel,
  input  logic                    tdi,
  input  logic [NREG*WIDTH-1:0]   cap_data,
  output logic                    tdo,
  output logic [NREG*WIDTH-1:0]   upd_data,
  output logic [NREG-1:0]         upd_strobe,
  output logic                    len_err
);

  localparam int            CW       = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);

  logic [WIDTH-1:0]            sr;
  logic                        byp;
  logic [CW-1:0]               cnt;
  logic [NREG-1:0][WIDTH-1:0]  shadow;

  logic                        sel_valid;
  logic                        len_ok;
  logic [WIDTH-1:0]            cap_sel;
  logic [NREG-1:0]             sel_hot;

  assign sel_valid = !bypass && (int'(sel) < NREG);
  assign len_ok    = (CHECK_LEN == 0) || (cnt == CNT_FULL);
  assign upd_data  = shadow;

  always_comb begin
    cap_sel = '0;
    sel_hot = '0;
    for (int unsigned k = 0; k < NREG; k++) begin
      if (sel == SELW'(k)) begin
        cap_sel    = cap_data[k*WIDTH +: WIDTH];
        sel_hot[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge tck or negedge reset) begin
    if (!reset) begin
      sr         <= '0;
      byp        <= 1'b0;
      cnt        <= '0;
      shadow     <= {NREG{RST_VAL}};
      upd_strobe <= '0;
      len_err    <= 1'b0;
    end else begin
      upd_strobe <= '0;
      if (capture_dr) begin
        byp     <= 1'b0;
        cnt     <= '0;
        len_err <= 1'b0;
        sr      <= sel_valid ? cap_sel : '0;
      end else if (shift_dr) begin
        if (bypass) begin
          byp <= tdi;
        end else begin
          sr  <= {tdi, sr[WIDTH-1:1]};
          cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end
      end else if (update_dr && sel_valid) begin
        if (len_ok) begin
          for (int unsigned k = 0; k < NREG; k++) begin
            if (sel_hot[k]) shadow[k] <= sr;
          end
          upd_strobe <= sel_hot;
        end else begin
          len_err <= 1'b1;
        end
      end
    end
  end

  // Falling-edge launch keeps each tdo bit stable across the downstream rising edge.
  always_ff @(negedge tck or negedge reset) begin
    if (!reset) tdo <= 1'b0;
    else        tdo <= bypass ? byp : sr[0];
  end

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Self-checking bench for jtag_dr_bank: expected tdo bits are queued as stimulus
// is driven and compared as each bit appears.
module tb_jtag_dr_bank;

  logic        tck = 1'b0;
  logic        reset;
  logic        capture_dr, shift_dr, update_dr, bypass, tdi;
  logic [1:0]  sel;
  logic [31:0] cap_data;
  logic        tdo;
  logic [31:0] upd_data;
  logic [3:0]  upd_strobe;
  logic        len_err;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic        exp_q[$];
  logic [7:0]  exp_shadow[4];

  jtag_dr_bank #(
    .NREG(4), .WIDTH(8), .SELW(2), .RST_VAL(8'hA5), .CHECK_LEN(1)
  ) dut (
    .tck(tck), .reset(reset), .capture_dr(capture_dr), .shift_dr(shift_dr),
    .update_dr(update_dr), .bypass(bypass), .sel(sel), .tdi(tdi),
    .cap_data(cap_data), .tdo(tdo), .upd_data(upd_data),
    .upd_strobe(upd_strobe), .len_err(len_err)
  );

  always #5 tck = ~tck;

  function automatic logic [31:0] exp_pack();
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[k*8 +: 8] = exp_shadow[k];
    return v;
  endfunction

  // Inputs change at negedge+1; outputs are sampled at negedge+1.
  task automatic tick();
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic tick_chk(input string name);
    logic e;
    tick();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, tdo=%0b", name, tdo);
    end else begin
      e = exp_q.pop_front();
      if (tdo !== e) begin
        errors++;
        $display("FAIL %s: tdo=%0b expected %0b", name, tdo, e);
      end
    end
  endtask

  task automatic scan(input logic b, input logic [1:0] s, input logic [7:0] cap,
                      input logic [7:0] din, input int unsigned n);
    bypass = b;
    sel    = s;
    cap_data[s*8 +: 8] = cap;
    capture_dr = 1'b1;
    exp_q.push_back(b ? 1'b0 : cap[0]);
    tick_chk("cap_tdo");
    capture_dr = 1'b0;
    checks++;
    if (len_err !== 1'b0) begin
      errors++;
      $display("FAIL cap_len_err: len_err=%0b expected 0", len_err);
    end
    shift_dr = 1'b1;
    for (int unsigned i = 1; i <= n; i++) begin
      tdi = din[(i-1) % 8];
      if (b)          exp_q.push_back(tdi);
      else if (i < 8) exp_q.push_back(cap[i]);
      else            exp_q.push_back(din[i-8]);
      tick_chk("shift_tdo");
    end
    shift_dr = 1'b0;
    tdi = 1'b0;
  endtask

  task automatic update(input logic [1:0] s, input logic commit,
                        input logic [7:0] nv, input logic exp_err);
    logic [3:0] exp_stb;
    sel = s;
    update_dr = 1'b1;
    if (commit) exp_shadow[s] = nv;
    exp_stb = commit ? (4'b0001 << s) : 4'b0000;
    tick();
    update_dr = 1'b0;
    checks++;
    if (upd_strobe !== exp_stb) begin
      errors++;
      $display("FAIL upd_strobe: got %b expected %b", upd_strobe, exp_stb);
    end
    checks++;
    if (upd_data !== exp_pack()) begin
      errors++;
      $display("FAIL upd_data: got %h expected %h", upd_data, exp_pack());
    end
    checks++;
    if (len_err !== exp_err) begin
      errors++;
      $display("FAIL upd_len_err: got %0b expected %0b", len_err, exp_err);
    end
    tick();
    checks++;
    if (upd_strobe !== 4'b0000) begin
      errors++;
      $display("FAIL strobe_pulse: got %b expected 0000", upd_strobe);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
    bypass = 1'b0; sel = 2'd0; tdi = 1'b0; cap_data = '0;
    for (int k = 0; k < 4; k++) exp_shadow[k] = 8'hA5;
    repeat (2) @(negedge tck);
    #1 reset = 1'b1;
    tick();
    checks++;
    if (upd_data !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL reset_data: got %h expected a5a5a5a5", upd_data);
    end
    checks++;
    if ({tdo, len_err, upd_strobe} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: tdo/len_err/strobe=%b expected 000000",
               {tdo, len_err, upd_strobe});
    end
  endtask

  task automatic test_full_scan();
    scan(1'b0, 2'd2, 8'h3C, 8'hC3, 8);
    update(2'd2, 1'b1, 8'hC3, 1'b0);
  endtask

  task automatic test_short_scan();
    scan(1'b0, 2'd1, 8'h77, 8'h12, 7);
    update(2'd1, 1'b0, 8'h00, 1'b1);
    scan(1'b0, 2'd1, 8'h77, 8'h00, 0);
  endtask

  task automatic test_long_scan();
    scan(1'b0, 2'd0, 8'hF0, 8'h96, 9);
    update(2'd0, 1'b0, 8'h00, 1'b1);
    scan(1'b0, 2'd0, 8'hF0, 8'h96, 8);
    update(2'd0, 1'b1, 8'h96, 1'b0);
  endtask

  task automatic test_bypass();
    scan(1'b1, 2'd2, 8'hFF, 8'h05, 3);
    update(2'd2, 1'b0, 8'h00, 1'b0);
    bypass = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    scan(1'b0, 2'd3, 8'h22, 8'h11, 8);
    update(2'd3, 1'b1, 8'h11, 1'b0);
    scan(1'b0, 2'd3, 8'hFF, 8'h00, 4);
    exp_q.delete();
    shift_dr = 1'b1;
    #2 reset = 1'b0;
    #1;
    shift_dr = 1'b0;
    for (int k = 0; k < 4; k++) exp_shadow[k] = 8'hA5;
    checks++;
    if (tdo !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_tdo: got %0b expected 0", tdo);
    end
    checks++;
    if (upd_data !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL rst_mid_data: got %h expected a5a5a5a5", upd_data);
    end
    @(negedge tck);
    #1 reset = 1'b1;
    scan(1'b0, 2'd3, 8'h4E, 8'hB2, 8);
    update(2'd3, 1'b1, 8'hB2, 1'b0);
  endtask

  task automatic test_capture_vs_update();
    scan(1'b0, 2'd2, 8'h00, 8'hE7, 8);
    cap_data[23:16] = 8'h5A;
    capture_dr = 1'b1;
    update_dr  = 1'b1;
    exp_q.push_back(1'b0);
    tick_chk("cap_upd_tdo");
    capture_dr = 1'b0;
    update_dr  = 1'b0;
    checks++;
    if (upd_strobe !== 4'b0000) begin
      errors++;
      $display("FAIL cap_upd_strobe: got %b expected 0000", upd_strobe);
    end
    checks++;
    if (upd_data !== exp_pack()) begin
      errors++;
      $display("FAIL cap_upd_data: got %h expected %h", upd_data, exp_pack());
    end
    shift_dr = 1'b1;
    exp_q.push_back(1'b1);
    tick_chk("cap_upd_shift");
    shift_dr = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_short_scan();
    test_long_scan();
    test_bypass();
    test_reset_mid_shift();
    test_capture_vs_update();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtag_dr_bank.md
Name: jtag_dr_bank

Overview:
- Parametrised bank of NREG user data registers, each WIDTH bits, plus a 1-bit bypass path, all behind one shared TDI→TDO shift path.
- The TAP controller provides the capture/shift/update enables and the instruction decoder provides the register select.
- Adds a shadow (update) stage per register, per-register update strobes, and shift-length checking. Updates from short or over-long scans are rejected and flagged.

Parameters:
- NREG, 4, number of user data registers.
- WIDTH, 32, bits per data register (≥2).
- SELW, 2, width of sel; must satisfy 2^SELW ≥ NREG.
- RST_VAL, 0, reset value (WIDTH bits) loaded into every shadow register.
- CHECK_LEN, 1, 1 = update only after exactly WIDTH shift cycles; 0 = no length check.

Ports:
- tck, input, 1, test clock; all state on rising edge except tdo.
- reset, input, 1, asynchronous active-low reset.
- capture_dr, input, 1, capture enable from TAP controller.
- shift_dr, input, 1, shift enable.
- update_dr, input, 1, update enable (one tck cycle in Update-DR).
- bypass, input, 1, 1 = bypass register selected.
- sel, input, SELW, user register index when bypass=0.
- tdi, input, 1, serial data in.
- cap_data, input, NREG*WIDTH, parallel capture values; register k occupies bits [k*WIDTH +: WIDTH].
- tdo, output, 1, serial data out, registered on falling tck.
- upd_data, output, NREG*WIDTH, shadow register contents, same packing as cap_data.
- upd_strobe, output, NREG, one-cycle pulse on the shadow register just written.
- len_err, output, 1, sticky flag: last update rejected for wrong shift length.

Behaviour:
- Internal state:
  - sr[WIDTH-1:0], shared shift stage.
  - byp, bypass bit.
  - cnt, shift counter, clog2(WIDTH+2) bits, saturates at WIDTH+1.
  - NREG shadow registers.
- Reset (reset=0, asynchronous, any time including mid-scan):
  - sr=0, byp=0, cnt=0.
  - every shadow register = RST_VAL.
  - upd_strobe=0, len_err=0, tdo=0.
  - On release, the first rising tck edge acts normally.
- Priority on a rising edge: capture_dr > shift_dr > update_dr. Lower-priority enables asserted in the same cycle are ignored.
- Valid selection: bypass=0 and sel<NREG. Anything else with bypass=0 is an invalid selection.
- Capture:
  - byp←0, cnt←0, len_err←0.
  - Valid selection: sr←cap_data slice[sel]. Invalid selection or bypass=1: sr←0.
- Shift, bypass=1: byp←tdi; sr and cnt hold.
- Shift, bypass=0: sr←{tdi, sr[WIDTH-1:1]} (LSB leaves first); cnt←min(cnt+1, WIDTH+1); byp holds.
- Update, valid selection, and (CHECK_LEN=0 or cnt==WIDTH):
  - shadow[sel]←sr.
  - upd_strobe[sel]=1 for exactly one cycle; all other strobe bits 0.
- Update, valid selection, CHECK_LEN=1, cnt≠WIDTH: shadow unchanged, no strobe, len_err←1.
- Update with bypass=1 or invalid selection: no effect on any state.
- upd_strobe is 0 in every cycle that is not a committing update. Back-to-back updates give back-to-back pulses.
- tdo: on the falling tck edge, tdo←(bypass ? byp : sr[0]). Each bit is stable for the whole next rising edge seen by the downstream device.
- Shift latency:
  - Selected register: a bit presented on tdi appears on tdo after WIDTH rising edges plus the following falling edge.
  - Bypass: after 1 rising edge plus the following falling edge.
- Changing sel or bypass between capture and update is allowed. The update applies to the sel/bypass values present in the update cycle; cnt is not reset by the change.
- Shadow registers change only on a committing update or reset; never during capture or shift.

Test Plan (NREG=4, WIDTH=8, CHECK_LEN=1, RST_VAL=8'hA5):
- Reset, then no scans → upd_data=32'hA5A5A5A5, tdo=0, len_err=0, upd_strobe=0.
- sel=2, cap_data slice2=8'h3C, capture, then 8 shifts of tdi=8'hC3 LSB-first → tdo emits 0,0,1,1,1,1,0,0 (8'h3C LSB-first). Update → upd_data slice2=8'hC3, upd_strobe=4'b0100 for one cycle, len_err=0.
- sel=1, capture, 7 shifts, update → slice1 stays 8'hA5, no strobe, len_err=1. Next capture clears len_err to 0.
- sel=0, capture, 9 shifts, update → cnt saturated, rejected, len_err=1. Repeat with 8 shifts → commits.
- bypass=1, capture, shift tdi=1,0,1 → tdo=0,1,0,1 (1-bit delay after the captured 0). Update → shadow registers and strobes unchanged.
- Assert reset mid-shift (after 4 of 8 shifts on sel=3, previously written 8'h11) → slice3=8'hA5, tdo=0 immediately. Subsequent full capture/shift/update works normally.
- capture_dr and update_dr asserted in the same cycle → capture occurs, no strobe, shadow unchanged.
